// File: rtl/axis_loader_pkg.sv
// rtl/axis_loader_pkg.sv - shared types and helpers for the AXI-Stream RAM loader
package axis_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DRAIN = 3'd2
    } state_t;

    localparam int ACP_DATA_WIDTH = 64;
    localparam int MAX_MEMS       = 32;

    // Out-of-range selects decode to all-zero so a bad index can never write.
    function automatic logic [MAX_MEMS-1:0] onehot(input int unsigned sel, input int unsigned num_mems);
        logic [MAX_MEMS-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < MAX_MEMS; i++) begin
            v[i] = (i == sel) && (sel < num_mems);
        end
        return v;
    endfunction

endpackage

// File: rtl/axis_ram_loader_if.sv
// rtl/axis_ram_loader_if.sv - config, stream and RAM-write bundle for the loader
interface axis_ram_loader_if
    import axis_loader_pkg::*;
#(
    parameter int DATA_WIDTH = ACP_DATA_WIDTH,
    parameter int ADDR_WIDTH = 12,
    parameter int NUM_MEMS   = 8,
    parameter int SEL_WIDTH  = 3
);
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [SEL_WIDTH-1:0]  cfg_sel;
    logic [ADDR_WIDTH:0]   cfg_length;

    logic [DATA_WIDTH-1:0] s_axis_tdata;
    logic                  s_axis_tvalid;
    logic                  s_axis_tready;
    logic                  s_axis_tlast;

    logic [NUM_MEMS-1:0]   ram_we;
    logic [ADDR_WIDTH-1:0] ram_adr;
    logic [DATA_WIDTH-1:0] ram_din;

    modport master (
        output cfg_valid, cfg_sel, cfg_length, s_axis_tdata, s_axis_tvalid, s_axis_tlast,
        input  cfg_ready, s_axis_tready, ram_we, ram_adr, ram_din
    );

    modport slave (
        input  cfg_valid, cfg_sel, cfg_length, s_axis_tdata, s_axis_tvalid, s_axis_tlast,
        output cfg_ready, s_axis_tready, ram_we, ram_adr, ram_din
    );
endinterface

// File: rtl/axis_ram_loader.sv
// rtl/axis_ram_loader.sv - AXI-Stream to multi-RAM loader with TLAST framing and status
module axis_ram_loader
    import axis_loader_pkg::*;
#(
    parameter int DATA_WIDTH   = ACP_DATA_WIDTH,
    parameter int ADDR_WIDTH   = 12,
    parameter int NUM_MEMS     = 8,
    parameter int SEL_WIDTH    = 3,
    parameter bit DROP_UNARMED = 1'b1
) (
    input  logic              CLK,
    input  logic              RST_N,
    axis_ram_loader_if.slave  bus,
    output logic              busy,
    output logic              done,
    output logic              err_overflow,
    output logic              err_underflow,
    output logic              err_badcfg,
    output logic [ADDR_WIDTH:0] beats_written
);

    localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                state_q, state_d;
    logic [SEL_WIDTH-1:0]  sel_q;
    logic [ADDR_WIDTH:0]   length_q;
    logic [ADDR_WIDTH:0]   count_q;
    logic [NUM_MEMS-1:0]   ram_we_q;
    logic [ADDR_WIDTH-1:0] ram_adr_q;
    logic [DATA_WIDTH-1:0] ram_din_q;
    logic                  done_q, ovf_q, unf_q, bad_q;
    logic [ADDR_WIDTH:0]   beats_q;

    logic                  tready, beat, last_beat, cfg_is_bad;
    logic                  wr_en, fin, set_ovf, set_unf, cfg_take, cfg_bad;
    logic [MAX_MEMS-1:0]   we_mask;

    // During reset the state register may still hold LOAD, so ready follows the idle rule.
    assign tready     = (RST_N && (state_q == ST_LOAD || state_q == ST_DRAIN)) ? 1'b1 : DROP_UNARMED;
    assign beat       = bus.s_axis_tvalid && tready;
    assign last_beat  = (count_q == length_q - 1'b1);
    assign cfg_is_bad = (bus.cfg_length == '0) || (bus.cfg_length > MAX_LEN)
                     || (32'(bus.cfg_sel) >= NUM_MEMS);
    assign we_mask    = onehot(32'(sel_q), NUM_MEMS);

    always_ff @(posedge CLK) begin
        if (!RST_N) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        wr_en    = 1'b0;
        fin      = 1'b0;
        set_ovf  = 1'b0;
        set_unf  = 1'b0;
        cfg_take = 1'b0;
        cfg_bad  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.cfg_valid) begin
                    cfg_take = 1'b1;
                    if (cfg_is_bad) begin
                        cfg_bad = 1'b1;
                        fin     = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                if (beat) begin
                    wr_en = 1'b1;
                    if (last_beat) begin
                        if (bus.s_axis_tlast) begin
                            fin     = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            set_ovf = 1'b1;
                            state_d = ST_DRAIN;
                        end
                    end else if (bus.s_axis_tlast) begin
                        set_unf = 1'b1;
                        fin     = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DRAIN: begin
                if (beat && bus.s_axis_tlast) begin
                    fin     = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sel_q     <= '0;
            length_q  <= '0;
            count_q   <= '0;
            ram_we_q  <= '0;
            ram_adr_q <= '0;
            ram_din_q <= '0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            bad_q     <= 1'b0;
            beats_q   <= '0;
        end else begin
            ram_we_q <= '0;
            done_q   <= fin;
            if (cfg_take) begin
                sel_q    <= bus.cfg_sel;
                length_q <= bus.cfg_length;
                count_q  <= '0;
                beats_q  <= '0;
                ovf_q    <= 1'b0;
                unf_q    <= 1'b0;
                bad_q    <= cfg_bad;
            end
            if (wr_en) begin
                ram_we_q  <= we_mask[NUM_MEMS-1:0];
                ram_adr_q <= count_q[ADDR_WIDTH-1:0];
                ram_din_q <= bus.s_axis_tdata;
                count_q   <= count_q + 1'b1;
                beats_q   <= count_q + 1'b1;
            end
            if (set_ovf) ovf_q <= 1'b1;
            if (set_unf) unf_q <= 1'b1;
        end
    end

    assign bus.cfg_ready     = RST_N && (state_q == ST_IDLE);
    assign bus.s_axis_tready = tready;
    assign bus.ram_we        = ram_we_q;
    assign bus.ram_adr       = ram_adr_q;
    assign bus.ram_din       = ram_din_q;

    assign busy          = RST_N && (state_q == ST_LOAD || state_q == ST_DRAIN);
    assign done          = done_q;
    assign err_overflow  = ovf_q;
    assign err_underflow = unf_q;
    assign err_badcfg    = bad_q;
    assign beats_written = beats_q;

endmodule
